dmi_axil_regfile: RTL

- AXI-Lite target register file that sits directly downstream of the DMI-to-AXI-Lite bridge and consumes its AXI-Lite initiator traffic.
- Implements a small word-addressed register bank reachable from JTAG/DMI.
- Word 0 is a read-only ID register; all other words are read/write with byte strobes.
- Handles AW/W/B and AR/R independently and responds with SLVERR for out-of-range or illegal accesses.

---
 rtl/dmi_axil_regfile.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmi_axil_regfile.sv
// dmi_axil_regfile
// AXI-Lite target register bank fed by the DMI-to-AXI-Lite bridge.
// Word 0 is a constant ID; words 1..NumRegs-1 are read/write with byte strobes.
// The write (AW/W/B) and read (AR/R) channels run independently of each other.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   aw_addr_i/valid/ready    write address channel (word index)
//   w_data_i/strb/valid/ready write data channel
//   b_resp_o/valid, b_ready_i write response (00 OKAY, 10 SLVERR)
//   ar_addr_i/valid/ready    read address channel (word index)
//   r_data_o/resp/valid, r_ready_i read response
//   regs_o                   registered view of every word, word i at [32i+31:32i]
module dmi_axil_regfile #(
  parameter int unsigned AddrWidth  = 7,
  parameter int unsigned NumRegs    = 16,
  parameter logic [31:0] IdValue    = 32'h00000DB3,
  parameter logic [31:0] ResetValue = 32'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [31:0]            w_data_i,
  input  logic [3:0]             w_strb_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  output logic [1:0]             b_resp_o,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  output logic [31:0]            r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [32*NumRegs-1:0]  regs_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic                 aw_held_reg;
  logic [AddrWidth-1:0] aw_addr_reg;
  logic                 w_held_reg;
  logic [31:0]          w_data_reg;
  logic [3:0]           w_strb_reg;
  logic                 b_valid_reg;
  logic [1:0]           b_resp_reg;
  logic                 r_valid_reg;
  logic [31:0]          r_data_reg;
  logic [1:0]           r_resp_reg;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 ar_hs;
  logic                 commit;
  logic [AddrWidth-1:0] cmt_addr;
  logic [31:0]          cmt_data;
  logic [3:0]           cmt_strb;
  logic                 cmt_legal;
  logic [31:0]          rd_data_next;
  logic [1:0]           rd_resp_next;

  // Each channel stops accepting once it holds a beat, and both stop while a
  // response is outstanding, so at most one write is ever in flight.
  assign aw_ready_o = !aw_held_reg && !b_valid_reg;
  assign w_ready_o  = !w_held_reg && !b_valid_reg;
  assign ar_ready_o = !r_valid_reg;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i && w_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // Commit on the edge that completes the second handshake (or both at once).
  // Whichever half arrives on this edge is taken straight from the inputs.
  assign commit   = (aw_hs || aw_held_reg) && (w_hs || w_held_reg);
  assign cmt_addr = aw_held_reg ? aw_addr_reg : aw_addr_i;
  assign cmt_data = w_held_reg ? w_data_reg : w_data_i;
  assign cmt_strb = w_held_reg ? w_strb_reg : w_strb_i;
  assign cmt_legal = (cmt_addr != '0) && (32'(cmt_addr) < NumRegs);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      b_valid_reg <= 1'b0;
      b_resp_reg  <= RespOkay;
    end else begin
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= aw_addr_i;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= w_data_i;
          w_strb_reg <= w_strb_i;
        end
      end

      if (commit) begin
        b_valid_reg <= 1'b1;
        b_resp_reg  <= cmt_legal ? RespOkay : RespSlvErr;
      end else if (b_valid_reg && b_ready_i) begin
        b_valid_reg <= 1'b0;
      end
    end
  end

  assign b_valid_o = b_valid_reg;
  assign b_resp_o  = b_resp_reg;

  // Storage: word 0 is the constant ID, the rest are byte-writable registers.
  // A word is selected only by an exact in-range address match, so illegal
  // addresses never touch state.
  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_word
    if (gi == 0) begin : g_id
      assign regs_o[31:0] = IdValue;
    end else begin : g_rw
      logic [31:0] word_reg;
      logic        wr_sel;

      assign wr_sel = commit && (cmt_addr == AddrWidth'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          word_reg <= ResetValue;
        end else if (wr_sel) begin
          for (int k = 0; k < 4; k++) begin
            if (cmt_strb[k]) begin
              word_reg[8*k +: 8] <= cmt_data[8*k +: 8];
            end
          end
        end
      end

      assign regs_o[32*gi +: 32] = word_reg;
    end
  end

  // Read mux over the pre-edge bank; a write committing on the same edge is
  // therefore not visible to this read.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RespSlvErr;
    for (int i = 0; i < NumRegs; i++) begin
      if (ar_addr_i == AddrWidth'(i)) begin
        rd_data_next = regs_o[32*i +: 32];
        rd_resp_next = RespOkay;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_resp_reg  <= RespOkay;
    end else if (ar_hs) begin
      r_valid_reg <= 1'b1;
      r_data_reg  <= rd_data_next;
      r_resp_reg  <= rd_resp_next;
    end else if (r_valid_reg && r_ready_i) begin
      r_valid_reg <= 1'b0;
    end
  end

  assign r_valid_o = r_valid_reg;
  assign r_data_o  = r_data_reg;
  assign r_resp_o  = r_resp_reg;

endmodule
